// File: rtl/syn_mulberry_bus_responder.sv
// Mulberry bus responder: round-robin arbitration of client arithmetic requests onto one shared
// pipelined multiplier and one radix-2 restoring divider, one operation in flight at a time.
module syn_mulberry_bus_responder #(
  parameter int unsigned P_NUM_CLIENTS = 4,
  parameter int unsigned P_MUL_LAT     = 2,
  parameter int unsigned P_OPND_W      = 16
) (
  input  logic                                  clk_ir,
  input  logic                                  rst_sync,
  input  logic [2*P_NUM_CLIENTS-1:0]            client_sid,
  input  logic [2*P_OPND_W*P_NUM_CLIENTS-1:0]   client_req_data,
  output logic [P_NUM_CLIENTS-1:0]              client_req_rdy,
  output logic [P_NUM_CLIENTS-1:0]              client_res_valid,
  output logic [2*P_OPND_W-1:0]                 client_res,
  output logic                                  busy
);

  localparam int unsigned LP_IDX_W   = (P_NUM_CLIENTS > 1) ? $clog2(P_NUM_CLIENTS) : 1;
  localparam int unsigned LP_CNT_MAX = (P_MUL_LAT > P_OPND_W) ? P_MUL_LAT : P_OPND_W;
  localparam int unsigned LP_CNT_W   = $clog2(LP_CNT_MAX + 1);
  localparam int unsigned LP_RES_W   = 2 * P_OPND_W;
  localparam logic [LP_IDX_W:0]   LP_N        = (LP_IDX_W + 1)'(P_NUM_CLIENTS);
  localparam logic [LP_IDX_W-1:0] LP_LAST     = LP_IDX_W'(P_NUM_CLIENTS - 1);
  localparam logic [LP_CNT_W-1:0] LP_MUL_LAST = LP_CNT_W'(P_MUL_LAT - 1);
  localparam logic [LP_CNT_W-1:0] LP_DIV_LAST = LP_CNT_W'(P_OPND_W - 1);

  typedef enum logic [1:0] {
    SID_IDLE = 2'd0,
    SID_MUL  = 2'd1,
    SID_DIV  = 2'd2,
    SID_RSVD = 2'd3
  } sid_e;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    MUL_S  = 2'd1,
    DIV_S  = 2'd2,
    RSP_S  = 2'd3
  } state_e;

  state_e                r_state;
  logic [LP_IDX_W-1:0]   r_ptr;
  logic [LP_IDX_W-1:0]   r_grant;
  logic [LP_CNT_W-1:0]   r_cnt;
  logic [P_NUM_CLIENTS-1:0] r_req_rdy;
  logic [P_NUM_CLIENTS-1:0] r_res_valid;
  logic [LP_RES_W-1:0]   r_res;
  logic                  r_busy;
  logic [P_OPND_W-1:0]   r_dq;
  logic [P_OPND_W-1:0]   r_rem;
  logic [P_OPND_W-1:0]   r_b;
  logic [LP_RES_W-1:0]   r_mul_pipe [P_MUL_LAT];

  logic                  w_found;
  logic                  w_win_div;
  logic [LP_IDX_W-1:0]   w_win;
  logic [LP_IDX_W:0]     w_cand;
  logic [1:0]            w_cand_sid;
  logic [LP_RES_W-1:0]   w_sel_data;
  logic [P_OPND_W-1:0]   w_sel_a;
  logic [P_OPND_W-1:0]   w_sel_b;
  logic [P_OPND_W:0]     w_trial;
  logic [P_OPND_W:0]     w_diff;
  logic                  w_ge;
  logic [P_OPND_W-1:0]   w_rem_nxt;
  logic [P_OPND_W-1:0]   w_dq_nxt;

  assign client_req_rdy   = r_req_rdy;
  assign client_res_valid = r_res_valid;
  assign client_res       = r_res;
  assign busy             = r_busy;

  // Round-robin search starting at r_ptr; reserved and idle sids are never eligible.
  always_comb begin
    w_found    = 1'b0;
    w_win      = '0;
    w_win_div  = 1'b0;
    w_cand     = '0;
    w_cand_sid = '0;
    for (int unsigned i = 0; i < P_NUM_CLIENTS; i++) begin
      w_cand = {1'b0, r_ptr} + (LP_IDX_W + 1)'(i);
      if (w_cand >= LP_N) begin
        w_cand = w_cand - LP_N;
      end
      w_cand_sid = client_sid[2*int'(w_cand) +: 2];
      if (!w_found && (w_cand_sid == SID_MUL || w_cand_sid == SID_DIV)) begin
        w_found   = 1'b1;
        w_win     = w_cand[LP_IDX_W-1:0];
        w_win_div = (w_cand_sid == SID_DIV);
      end
    end
  end

  assign w_sel_data = client_req_data[int'(w_win)*LP_RES_W +: LP_RES_W];
  assign w_sel_a    = w_sel_data[LP_RES_W-1:P_OPND_W];
  assign w_sel_b    = w_sel_data[P_OPND_W-1:0];

  // One restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
  // With B==0 every step subtracts zero, yielding an all-ones quotient and R=A.
  always_comb begin
    w_trial   = {r_rem, r_dq[P_OPND_W-1]};
    w_diff    = w_trial - {1'b0, r_b};
    w_ge      = (w_trial >= {1'b0, r_b});
    w_rem_nxt = w_ge ? w_diff[P_OPND_W-1:0] : w_trial[P_OPND_W-1:0];
    w_dq_nxt  = {r_dq[P_OPND_W-2:0], w_ge};
  end

  // Product enters at grant from the selected operands; the last stage holds it exactly when
  // MUL_S finishes, so the delay line can run freely every cycle.
  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      for (int unsigned i = 0; i < P_MUL_LAT; i++) begin
        r_mul_pipe[i] <= '0;
      end
    end else begin
      r_mul_pipe[0] <= LP_RES_W'(w_sel_a) * LP_RES_W'(w_sel_b);
      for (int unsigned i = 1; i < P_MUL_LAT; i++) begin
        r_mul_pipe[i] <= r_mul_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      r_state     <= IDLE_S;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_cnt       <= '0;
      r_req_rdy   <= '0;
      r_res_valid <= '0;
      r_res       <= '0;
      r_busy      <= 1'b0;
      r_dq        <= '0;
      r_rem       <= '0;
      r_b         <= '0;
    end else begin
      r_req_rdy   <= '0;
      r_res_valid <= '0;
      case (r_state)
        IDLE_S: begin
          if (w_found) begin
            r_grant   <= w_win;
            r_ptr     <= (w_win == LP_LAST) ? '0 : w_win + 1'b1;
            r_cnt     <= '0;
            r_req_rdy <= P_NUM_CLIENTS'(1) << w_win;
            r_dq      <= w_sel_a;
            r_rem     <= '0;
            r_b       <= w_sel_b;
            r_busy    <= 1'b1;
            r_state   <= w_win_div ? DIV_S : MUL_S;
          end
        end
        MUL_S: begin
          if (r_cnt == LP_MUL_LAST) begin
            r_res       <= r_mul_pipe[P_MUL_LAT-1];
            r_res_valid <= P_NUM_CLIENTS'(1) << r_grant;
            r_state     <= RSP_S;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DIV_S: begin
          r_dq  <= w_dq_nxt;
          r_rem <= w_rem_nxt;
          if (r_cnt == LP_DIV_LAST) begin
            r_res       <= {w_dq_nxt, w_rem_nxt};
            r_res_valid <= P_NUM_CLIENTS'(1) << r_grant;
            r_state     <= RSP_S;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RSP_S: begin
          r_busy  <= 1'b0;
          r_state <= IDLE_S;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE_S;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_syn_mulberry_bus_responder.sv
// Directed bench for syn_mulberry_bus_responder: expected grants and results are queued when
// requests are driven and matched against req_rdy / res_valid pulses cycle by cycle.
module tb_syn_mulberry_bus_responder;

  localparam int unsigned N       = 4;
  localparam int unsigned LAT     = 2;
  localparam int unsigned W       = 16;
  localparam int unsigned DIV_LAT = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_RSVD = 2'd3;

  logic              clk_ir = 1'b0;
  logic              rst_sync;
  logic [2*N-1:0]    client_sid;
  logic [2*W*N-1:0]  client_req_data;
  logic [N-1:0]      client_req_rdy;
  logic [N-1:0]      client_res_valid;
  logic [2*W-1:0]    client_res;
  logic              busy;

  typedef struct {
    int unsigned client;
    logic [31:0] res;
    int unsigned due;
  } res_t;

  typedef struct {
    int unsigned client;
    int unsigned due;
  } rdy_t;

  res_t res_q[$];
  rdy_t rdy_q[$];
  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  syn_mulberry_bus_responder #(
    .P_NUM_CLIENTS(N),
    .P_MUL_LAT(LAT),
    .P_OPND_W(W)
  ) dut (
    .clk_ir(clk_ir),
    .rst_sync(rst_sync),
    .client_sid(client_sid),
    .client_req_data(client_req_data),
    .client_req_rdy(client_req_rdy),
    .client_res_valid(client_res_valid),
    .client_res(client_res),
    .busy(busy)
  );

  always #5 clk_ir = ~clk_ir;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input bit is_div, input logic [15:0] a, input logic [15:0] b);
    if (!is_div) return 32'(a) * 32'(b);
    if (b == 16'd0) return {16'hFFFF, a};
    return {a / b, a % b};
  endfunction

  task automatic set_req(input int unsigned i, input logic [1:0] sid, input logic [15:0] a,
                         input logic [15:0] b);
    client_sid[2*i +: 2]       = sid;
    client_req_data[32*i +: 32] = {a, b};
  endtask

  task automatic expect_op(input int unsigned i, input bit is_div, input logic [15:0] a,
                           input logic [15:0] b, input int unsigned gcyc);
    rdy_t r;
    res_t s;
    r.client = i;
    r.due    = gcyc + 1;
    rdy_q.push_back(r);
    s.client = i;
    s.res    = model(is_div, a, b);
    s.due    = gcyc + 1 + (is_div ? DIV_LAT : LAT);
    res_q.push_back(s);
  endtask

  task automatic tick();
    rdy_t r;
    res_t s;
    @(posedge clk_ir);
    #1;
    cyc++;
    chk("rdy_onehot0", 32'($onehot0(client_req_rdy)), 32'd1);
    chk("res_onehot0", 32'($onehot0(client_res_valid)), 32'd1);
    if (client_req_rdy != '0) begin
      if (rdy_q.size() == 0) begin
        chk("rdy_unexpected", 32'(client_req_rdy), 32'd0);
      end else begin
        r = rdy_q.pop_front();
        chk("rdy_client", 32'(client_req_rdy), 32'(1 << r.client));
        chk("rdy_cycle", cyc, r.due);
      end
    end else if (rdy_q.size() != 0 && rdy_q[0].due <= cyc) begin
      r = rdy_q.pop_front();
      chk("rdy_missing", 32'(client_req_rdy), 32'(1 << r.client));
    end
    if (client_res_valid != '0) begin
      if (res_q.size() == 0) begin
        chk("res_unexpected", 32'(client_res_valid), 32'd0);
      end else begin
        s = res_q.pop_front();
        chk("res_client", 32'(client_res_valid), 32'(1 << s.client));
        chk("res_value", client_res, s.res);
        chk("res_cycle", cyc, s.due);
      end
    end else if (res_q.size() != 0 && res_q[0].due <= cyc) begin
      s = res_q.pop_front();
      chk("res_missing", 32'(client_res_valid), 32'(1 << s.client));
    end
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  logic [15:0] div_a [5] = '{16'h1000, 16'h1234, 16'h0005, 16'hFFFF, 16'hFFFF};
  logic [15:0] div_b [5] = '{16'h0003, 16'h0000, 16'h0009, 16'h0001, 16'hFFFF};
  logic [15:0] rr_a  [3] = '{16'hFFFF, 16'h1234, 16'h8000};
  logic [15:0] rr_b  [3] = '{16'hFFFF, 16'hABCD, 16'h0002};
  int unsigned rr_id [3] = '{0, 2, 3};

  initial begin
    int unsigned c0;
    client_sid      = '0;
    client_req_data = '0;
    rst_sync        = 1'b1;
    repeat (3) tick();
    chk("rst_req_rdy", 32'(client_req_rdy), 32'd0);
    chk("rst_res_valid", 32'(client_res_valid), 32'd0);
    chk("rst_res", client_res, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_sync = 1'b0;
    tick();

    // Single multiply, fixed latency
    set_req(0, S_MUL, 16'h00FF, 16'h0080);
    expect_op(0, 1'b0, 16'h00FF, 16'h0080, cyc);
    tick();
    chk("t1_busy", 32'(busy), 32'd1);
    set_req(0, S_IDLE, 16'h0, 16'h0);
    wait_idle("t1");
    chk("t1_res_held", client_res, 32'h0000_7F80);

    // Divides including divide-by-zero
    for (int k = 0; k < 5; k++) begin
      set_req(1, S_DIV, div_a[k], div_b[k]);
      expect_op(1, 1'b1, div_a[k], div_b[k], cyc);
      tick();
      set_req(1, S_IDLE, 16'h0, 16'h0);
      wait_idle("t2");
    end

    // MUL followed by DIV raised the cycle after res_valid
    set_req(0, S_MUL, 16'h1234, 16'h5678);
    expect_op(0, 1'b0, 16'h1234, 16'h5678, cyc);
    tick();
    set_req(0, S_IDLE, 16'h0, 16'h0);
    repeat (3) tick();
    chk("t4_no_dead_cycle", 32'(busy), 32'd0);
    set_req(0, S_DIV, 16'h7FFF, 16'h0010);
    expect_op(0, 1'b1, 16'h7FFF, 16'h0010, cyc);
    tick();
    set_req(0, S_IDLE, 16'h0, 16'h0);
    wait_idle("t4");

    // Round robin among clients 0,2,3 from a fresh reset
    rst_sync = 1'b1;
    tick();
    rst_sync = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 3; k++) set_req(rr_id[k], S_MUL, rr_a[k], rr_b[k]);
    for (int k = 0; k < 6; k++) expect_op(rr_id[k%3], 1'b0, rr_a[k%3], rr_b[k%3], c0 + 4*k);
    repeat (21) tick();
    for (int k = 0; k < 3; k++) set_req(rr_id[k], S_IDLE, 16'h0, 16'h0);
    wait_idle("t3");

    // Reserved sid on client 2 is never granted
    set_req(2, S_RSVD, 16'h4444, 16'h5555);
    for (int k = 0; k < 2; k++) begin
      set_req(1, S_MUL, 16'h0101, 16'h0101);
      expect_op(1, 1'b0, 16'h0101, 16'h0101, cyc);
      tick();
      set_req(1, S_IDLE, 16'h0, 16'h0);
      wait_idle("t6");
    end
    repeat (5) tick();
    set_req(2, S_IDLE, 16'h0, 16'h0);

    // Reset in the middle of a divide; pending requests resume from pointer 0
    c0 = cyc;
    set_req(1, S_DIV, 16'hABCD, 16'h0007);
    begin
      rdy_t r;
      r.client = 1;
      r.due    = c0 + 1;
      rdy_q.push_back(r);
    end
    tick();
    set_req(1, S_IDLE, 16'h0, 16'h0);
    set_req(0, S_MUL, 16'h00AA, 16'h0055);
    set_req(3, S_MUL, 16'h0F0F, 16'h00F0);
    repeat (7) tick();
    chk("t5_mid_div_busy", 32'(busy), 32'd1);
    rst_sync = 1'b1;
    tick();
    chk("t5_rst_req_rdy", 32'(client_req_rdy), 32'd0);
    chk("t5_rst_res_valid", 32'(client_res_valid), 32'd0);
    chk("t5_rst_res", client_res, 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    rst_sync = 1'b0;
    expect_op(0, 1'b0, 16'h00AA, 16'h0055, cyc);
    expect_op(3, 1'b0, 16'h0F0F, 16'h00F0, cyc + 4);
    tick();
    set_req(0, S_IDLE, 16'h0, 16'h0);
    repeat (4) tick();
    set_req(3, S_IDLE, 16'h0, 16'h0);
    wait_idle("t5");
    repeat (20) tick();

    chk("rdy_queue_drained", rdy_q.size(), 32'd0);
    chk("res_queue_drained", res_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
